// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg: shared types and constants for the mux select arbiter.
//   state_e : arbiter FSM states (IDLE, OWN_A, OWN_B)
//   SEL_A/B : mux select encodings (0 routes A, 1 routes B)
package mux_sel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_sel_beat_cnt.sv
// mux_sel_beat_cnt: loadable down-counter holding the beats left in a burst.
//   clk, rst_n : clock, async active-low reset
//   clear      : force remain to 0 (burst finished with nobody to serve next)
//   load, len  : load a new burst length; a length of 0 loads as 1
//   dec        : one beat accepted
//   remain     : beats left in the current burst
//   last       : remain == 1, i.e. the next accepted beat ends the burst
// Priority: clear > load > dec.
module mux_sel_beat_cnt #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  input  logic             dec,
  output logic [LEN_W-1:0] remain,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain <= '0;
    end else if (clear) begin
      remain <= '0;
    end else if (load) begin
      remain <= (len == '0) ? LEN_W'(1) : len;
    end else if (dec && (remain != '0)) begin
      // Guarded so the counter can never wrap below zero.
      remain <= remain - LEN_W'(1);
    end
  end

  assign last = (remain == LEN_W'(1));

endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin burst arbiter driving the select of a 2:1 mux.
// The select is held for a whole granted burst so the data path never
// switches mid-burst; hand-over to the next requester happens with no
// idle cycle in between.
//   clk, rst_n     : clock, async active-low reset
//   req_a, len_a   : requester A level request and burst length
//   req_b, len_b   : requester B level request and burst length
//   adv            : downstream accepted one beat this cycle
//   s              : mux select (0 = A, 1 = B), held in IDLE
//   gnt_a, gnt_b   : ownership of the mux
//   busy           : a grant is active
//   remain         : beats left in the current burst
//   tmo            : one-cycle pulse when a grant is released by timeout
// Optional feature macro: MUX_SEL_TIMEOUT_EN adds the TIMEOUT parameter,
// the idle-beat counter and the tmo output.
//
// state | meaning
// IDLE  | no owner, s keeps its last value
// OWN_A | A owns the mux, s = 0
// OWN_B | B owns the mux, s = 1
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int LEN_W   = 4
`ifdef MUX_SEL_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [LEN_W-1:0] len_a,
  input  logic             req_b,
  input  logic [LEN_W-1:0] len_b,
  input  logic             adv,
  output logic             s,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             busy,
  output logic [LEN_W-1:0] remain
`ifdef MUX_SEL_TIMEOUT_EN
  , output logic           tmo
`endif
);

  state_e state;
  logic   last_served;
  logic   in_own;
  logic   cnt_last;
  logic   timeout_hit;
  logic   burst_end;
  logic   take;
  logic   prio_ref;
  logic   grant_a;
  logic   grant_b;
  logic   cnt_load;
  logic   cnt_clear;

  assign in_own    = (state != IDLE);
  assign burst_end = in_own && ((adv && cnt_last) || timeout_hit);
  assign take      = (state == IDLE) || burst_end;

  // On a tie the winner is whoever was not served last. At a burst end the
  // current owner is about to become last_served, so it is used directly.
  assign prio_ref = (state == OWN_A) ? SEL_A :
                    (state == OWN_B) ? SEL_B : last_served;

  assign grant_a = take && req_a && (!req_b || (prio_ref == SEL_B));
  assign grant_b = take && req_b && (!req_a || (prio_ref == SEL_A));

  assign cnt_load  = grant_a || grant_b;
  assign cnt_clear = burst_end && !cnt_load;

  mux_sel_beat_cnt #(.LEN_W(LEN_W)) u_beat_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear),
    .load   (cnt_load),
    .len    (grant_b ? len_b : len_a),
    .dec    (in_own && adv),
    .remain (remain),
    .last   (cnt_last)
  );

`ifdef MUX_SEL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] idle_cnt;

  // Fires on the TIMEOUT-th consecutive owned cycle without a beat.
  assign timeout_hit = in_own && !adv && (idle_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      tmo      <= 1'b0;
    end else begin
      tmo <= timeout_hit;
      if (!in_own || adv || burst_end || cnt_load) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      s           <= SEL_A;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      busy        <= 1'b0;
      last_served <= SEL_B;
    end else begin
      if (burst_end) begin
        last_served <= (state == OWN_B) ? SEL_B : SEL_A;
      end
      if (grant_a) begin
        state <= OWN_A;
        s     <= SEL_A;
        gnt_a <= 1'b1;
        gnt_b <= 1'b0;
        busy  <= 1'b1;
      end else if (grant_b) begin
        state <= OWN_B;
        s     <= SEL_B;
        gnt_a <= 1'b0;
        gnt_b <= 1'b1;
        busy  <= 1'b1;
      end else if (burst_end) begin
        state <= IDLE;
        gnt_a <= 1'b0;
        gnt_b <= 1'b0;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed, table-driven bench for mux_sel_arbiter.
// Each table row gives the inputs for one cycle and the outputs expected
// just after the following rising edge. Hand-written sequences cover async
// reset mid-burst, mid-burst input changes and (with MUX_SEL_TIMEOUT_EN)
// the timeout release.
module tb_mux_sel_arbiter;

  typedef struct {
    logic       ra;
    logic [3:0] la;
    logic       rb;
    logic [3:0] lb;
    logic       adv;
    logic       es;
    logic       ega;
    logic       egb;
    logic       ebsy;
    logic [3:0] erem;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       req_a;
  logic [3:0] len_a;
  logic       req_b;
  logic [3:0] len_b;
  logic       adv;
  logic       s;
  logic       gnt_a;
  logic       gnt_b;
  logic       busy;
  logic [3:0] remain;
`ifdef MUX_SEL_TIMEOUT_EN
  logic       tmo;
`endif

  int compared   = 0;
  int mismatched = 0;

  vec_t tbl [24];

`ifdef MUX_SEL_TIMEOUT_EN
  mux_sel_arbiter #(.LEN_W(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .len_a(len_a), .req_b(req_b),
    .len_b(len_b), .adv(adv), .s(s), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .busy(busy), .remain(remain), .tmo(tmo)
  );
`else
  mux_sel_arbiter #(.LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .len_a(len_a), .req_b(req_b),
    .len_b(len_b), .adv(adv), .s(s), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .busy(busy), .remain(remain)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic ra, logic [3:0] la, logic rb, logic [3:0] lb,
                              logic av, logic es, logic ega, logic egb,
                              logic ebsy, logic [3:0] erem);
    vec_t v;
    v.ra = ra; v.la = la; v.rb = rb; v.lb = lb; v.adv = av;
    v.es = es; v.ega = ega; v.egb = egb; v.ebsy = ebsy; v.erem = erem;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Packed as {s, gnt_a, gnt_b, busy, remain}.
  task automatic expect_out(string name, logic es, logic ega, logic egb,
                            logic ebsy, logic [3:0] erem);
    chk(name, {s, gnt_a, gnt_b, busy, remain}, {es, ega, egb, ebsy, erem});
  endtask

  task automatic check_inv();
    chk("inv_onehot", {7'd0, gnt_a & gnt_b}, 8'd0);
    chk("inv_busy", {7'd0, busy}, {7'd0, gnt_a | gnt_b});
    if (busy) chk("inv_sel", {7'd0, s}, {7'd0, gnt_b});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_inv();
  endtask

  task automatic drive(logic ra, logic [3:0] la, logic rb, logic [3:0] lb, logic av);
    req_a = ra; len_a = la; req_b = rb; len_b = lb; adv = av;
  endtask

  initial begin
    // ra la  rb lb  adv | s ga gb bsy rem
    tbl[0]  = mk(1, 2, 1, 1,  1, 0, 1, 0, 1, 2);   // tie from reset: A first
    tbl[1]  = mk(1, 2, 1, 1,  1, 0, 1, 0, 1, 1);
    tbl[2]  = mk(1, 2, 1, 1,  1, 1, 0, 1, 1, 1);   // hand-over to B, no gap
    tbl[3]  = mk(1, 2, 0, 1,  1, 0, 1, 0, 1, 2);   // back to A
    tbl[4]  = mk(0, 2, 0, 1,  0, 0, 1, 0, 1, 2);   // adv=0 holds
    tbl[5]  = mk(0, 2, 0, 1,  1, 0, 1, 0, 1, 1);
    tbl[6]  = mk(0, 2, 0, 1,  1, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 3, 0, 1,  1, 0, 1, 0, 1, 3);   // single A, len 3
    tbl[8]  = mk(0, 3, 0, 1,  1, 0, 1, 0, 1, 2);
    tbl[9]  = mk(0, 3, 0, 1,  1, 0, 1, 0, 1, 1);
    tbl[10] = mk(0, 3, 0, 1,  1, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 3, 0, 1,  1, 0, 0, 0, 0, 0);   // adv in IDLE ignored
    tbl[12] = mk(0, 3, 1, 0,  0, 1, 0, 1, 1, 1);   // len 0 -> 1 beat
    tbl[13] = mk(0, 3, 0, 0,  1, 1, 0, 0, 0, 0);   // s held in IDLE
    tbl[14] = mk(0, 3, 0, 0,  0, 1, 0, 0, 0, 0);
    tbl[15] = mk(0, 3, 1, 2,  1, 1, 0, 1, 1, 2);   // B len 2, adv 1,0,0,1
    tbl[16] = mk(0, 3, 0, 2,  1, 1, 0, 1, 1, 1);
    tbl[17] = mk(0, 3, 0, 2,  0, 1, 0, 1, 1, 1);
    tbl[18] = mk(0, 3, 0, 2,  0, 1, 0, 1, 1, 1);
    tbl[19] = mk(0, 3, 0, 2,  1, 1, 0, 0, 0, 0);
    tbl[20] = mk(1, 1, 0, 2,  0, 0, 1, 0, 1, 1);   // s returns to A
    tbl[21] = mk(0, 1, 0, 2,  1, 0, 0, 0, 0, 0);
    tbl[22] = mk(0, 1, 1, 15, 0, 1, 0, 1, 1, 15);  // max length
    tbl[23] = mk(0, 1, 0, 15, 1, 1, 0, 1, 1, 14);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_vals", 0, 0, 0, 0, 0);
`ifdef MUX_SEL_TIMEOUT_EN
    chk("reset_tmo", {7'd0, tmo}, 8'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].ra, tbl[i].la, tbl[i].rb, tbl[i].lb, tbl[i].adv);
      tick();
      expect_out($sformatf("vec%0d", i), tbl[i].es, tbl[i].ega, tbl[i].egb,
                 tbl[i].ebsy, tbl[i].erem);
    end

    // Async reset while B owns with 14 beats left, then B with 5 left.
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    expect_out("async_rst_14", 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 1, 5, 0);
    tick();
    expect_out("b_len5", 1, 0, 1, 1, 5);
    drive(0, 0, 1, 5, 0);
    #3;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst_5", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    expect_out("rst_held", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Tie after reset goes to A; B's aborted burst does not count as served.
    // A then drops its request and changes its length mid-burst.
    drive(1, 3, 1, 2, 0);
    tick();
    expect_out("tie_after_rst", 0, 1, 0, 1, 3);
    drive(0, 7, 1, 2, 1);
    tick();
    expect_out("midburst_2", 0, 1, 0, 1, 2);
    tick();
    expect_out("midburst_1", 0, 1, 0, 1, 1);
    tick();
    expect_out("midburst_to_b", 1, 0, 1, 1, 2);
    drive(0, 7, 0, 2, 1);
    tick();
    expect_out("b_rem1", 1, 0, 1, 1, 1);
    tick();
    expect_out("b_done", 1, 0, 0, 0, 0);

`ifdef MUX_SEL_TIMEOUT_EN
    // A stalls for four cycles with B waiting: timeout hands over to B.
    drive(1, 3, 0, 0, 0);
    tick();
    expect_out("tmo_grant_a", 0, 1, 0, 1, 3);
    drive(0, 3, 1, 2, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      expect_out($sformatf("tmo_wait%0d", i), 0, 1, 0, 1, 3);
      chk($sformatf("tmo_low%0d", i), {7'd0, tmo}, 8'd0);
    end
    tick();
    expect_out("tmo_to_b", 1, 0, 1, 1, 2);
    chk("tmo_pulse", {7'd0, tmo}, 8'd1);
    drive(0, 3, 0, 2, 1);
    tick();
    chk("tmo_clear", {7'd0, tmo}, 8'd0);
    expect_out("tmo_b_rem1", 1, 0, 1, 1, 1);
    tick();
    expect_out("tmo_b_done", 1, 0, 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
